// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: holds the PC, reads a 1-cycle-latency ROM, buffers
// returned words in a small prefetch FIFO and presents one registered
// instruction per cycle to decode (NOP bubble when empty, hold on stall,
// flush on redirect).
module instruction_fetch_queue #(
   parameter int                    INS_WIDTH  = 20,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      imem_req,
   output logic [ADDR_WIDTH-1:0]     imem_addr,
   input  logic [INS_WIDTH-1:0]      imem_rdata,
   input  logic                      stall,
   input  logic                      redirect,
   input  logic [ADDR_WIDTH-1:0]     redirect_pc,
   output logic [INS_WIDTH-1:0]      ins,
   output logic [ADDR_WIDTH-1:0]     ins_pc,
   output logic                      ins_valid,
   output logic [$clog2(DEPTH):0]    queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_rsp_pc;
   logic                  r_inflight;
   logic                  r_drop;

   logic [INS_WIDTH-1:0]  r_mem_ins [DEPTH];
   logic [ADDR_WIDTH-1:0] r_mem_pc  [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;

   logic [INS_WIDTH-1:0]  r_ins;
   logic [ADDR_WIDTH-1:0] r_ins_pc;
   logic                  r_ins_valid;

   logic [CW:0]           w_credit;
   logic                  w_req;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;

   // Outstanding credit: queued words plus the one read in flight. A pop in
   // the same cycle is deliberately not credited, keeping the issue path short.
   assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_req    = ~reset & ~redirect & (w_credit < (CW+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   // A response landing in a redirect cycle belongs to the old path; the
   // FIFO clear wins over the push.
   assign w_push   = r_inflight & ~r_drop & ~redirect;
   assign w_pop    = ~redirect & ~stall & ~w_empty;

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign ins         = r_ins;
   assign ins_pc      = r_ins_pc;
   assign ins_valid   = r_ins_valid;
   assign queue_count = r_count;

   // PC, in-flight tracking and the kill flag for a stale response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_rsp_pc   <= '0;
         r_inflight <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_inflight <= w_req;
         r_drop     <= redirect ? r_inflight : 1'b0;
         if (redirect) begin
            r_pc <= redirect_pc;
         end else if (w_req) begin
            r_pc     <= r_pc + 1'b1;
            r_rsp_pc <= r_pc;
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (redirect) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: word plus the address it was fetched from
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_ins[r_wptr] <= imem_rdata;
         r_mem_pc[r_wptr]  <= r_rsp_pc;
      end
   end

   // Decode-facing output register: redirect > stall > pop > bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ins       <= '0;
         r_ins_pc    <= '0;
         r_ins_valid <= 1'b0;
      end else if (redirect) begin
         r_ins       <= '0;
         r_ins_valid <= 1'b0;
      end else if (stall) begin
         r_ins       <= r_ins;
         r_ins_pc    <= r_ins_pc;
         r_ins_valid <= r_ins_valid;
      end else if (!w_empty) begin
         r_ins       <= r_mem_ins[r_rptr];
         r_ins_pc    <= r_mem_pc[r_rptr];
         r_ins_valid <= 1'b1;
      end else begin
         r_ins       <= '0;
         r_ins_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Testbench for instruction_fetch_queue: expected words are queued by the
// stimulus process, a monitor pops and compares each newly presented word.
module tb_instruction_fetch_queue;

   typedef struct {
      logic [19:0] ins;
      logic [9:0]  pc;
   } exp_t;

   logic        clk;
   logic        rst, stall, redirect;
   logic [9:0]  redirect_pc;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [19:0] imem_rdata;
   logic [19:0] ins;
   logic [9:0]  ins_pc;
   logic        ins_valid;
   logic [2:0]  queue_count;

   logic        rst2, stall2, redirect2;
   logic [9:0]  redirect_pc2;
   logic        req2;
   logic [9:0]  addr2;
   logic [19:0] rdata2;
   logic [19:0] ins2;
   logic [9:0]  ins_pc2;
   logic        valid2;
   logic [2:0]  qc2;

   exp_t q1[$];
   exp_t q2[$];
   int   total = 0;
   int   bad   = 0;
   logic en1 = 1'b0;
   logic en2 = 1'b0;

   instruction_fetch_queue #(.INS_WIDTH(20), .ADDR_WIDTH(10), .DEPTH(4), .RESET_PC(10'h000)) u_dut (
      .clk(clk), .reset(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .ins(ins), .ins_pc(ins_pc),
      .ins_valid(ins_valid), .queue_count(queue_count));

   instruction_fetch_queue #(.INS_WIDTH(20), .ADDR_WIDTH(10), .DEPTH(4), .RESET_PC(10'h3FE)) u_dut2 (
      .clk(clk), .reset(rst2), .imem_req(req2), .imem_addr(addr2),
      .imem_rdata(rdata2), .stall(stall2), .redirect(redirect2),
      .redirect_pc(redirect_pc2), .ins(ins2), .ins_pc(ins_pc2),
      .ins_valid(valid2), .queue_count(qc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] rom(input logic [9:0] a);
      return 20'h10000 + {10'd0, a};
   endfunction

   // synchronous ROMs, one-cycle read latency
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= rom(imem_addr);
      if (req2)     rdata2     <= rom(addr2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push1(input logic [9:0] pc);
      exp_t e;
      e.ins = 20'h10000 + {10'd0, pc};
      e.pc  = pc;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [9:0] pc);
      exp_t e;
      e.ins = 20'h10000 + {10'd0, pc};
      e.pc  = pc;
      q2.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // a word is newly presented when the edge that loaded it had no stall/redirect/reset
   always @(posedge clk) begin
      en1 = ~stall & ~redirect & ~rst;
      en2 = ~stall2 & ~rst2;
   end

   always @(negedge clk) begin
      exp_t e;
      if (en1 && ins_valid) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL d1_extra: got pc %0h expected no word", ins_pc);
         end else begin
            e = q1.pop_front();
            chk("d1_ins", {12'd0, ins}, {12'd0, e.ins});
            chk("d1_pc", {22'd0, ins_pc}, {22'd0, e.pc});
         end
      end
      if (en2 && valid2) begin
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL d2_extra: got pc %0h expected no word", ins_pc2);
         end else begin
            e = q2.pop_front();
            chk("d2_ins", {12'd0, ins2}, {12'd0, e.ins});
            chk("d2_pc", {22'd0, ins_pc2}, {22'd0, e.pc});
         end
      end
   end

   initial begin
      rst = 1'b1; rst2 = 1'b1; stall = 1'b0; stall2 = 1'b0;
      redirect = 1'b0; redirect_pc = '0; redirect2 = 1'b0; redirect_pc2 = '0;
      repeat (3) step();
      chk("rst_ins", ins, 0);
      chk("rst_vld", ins_valid, 0);
      chk("rst_pc", ins_pc, 0);
      chk("rst_qc", queue_count, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst2_addr", addr2, 10'h3FE);

      for (int p = 0; p <= 10; p++) push1(10'(p));
      push2(10'h3FE); push2(10'h3FF); push2(10'h000); push2(10'h001);
      rst = 1'b0; rst2 = 1'b0;
      #1 chk("req_after_rst", imem_req, 1);

      // edges 0..7: free run
      for (int e = 0; e < 8; e++) begin
         step();
         chk("qc_le1", queue_count <= 3'd1, 1);
         if (e < 2) chk("early_vld", ins_valid, 0);
         if (e == 5) stall2 = 1'b1;
      end

      // edges 8..13: stall, output frozen on word 5, queue fills
      stall = 1'b1;
      for (int e = 8; e < 14; e++) begin
         step();
         chk("stall_ins", ins, 20'h10005);
         chk("stall_pc", ins_pc, 10'h005);
         if (e >= 10) begin
            chk("stall_qc", queue_count, 4);
            chk("stall_req", imem_req, 0);
         end
      end
      stall = 1'b0;

      // edges 14..18: drain without gaps
      for (int e = 14; e < 19; e++) begin
         step();
         chk("drain_vld", ins_valid, 1);
      end
      chk("pre_redir_qc", queue_count, 2);

      // redirect with 2 queued and one in flight
      redirect = 1'b1; redirect_pc = 10'h200;
      #1 chk("redir_req", imem_req, 0);
      push1(10'h200); push1(10'h201); push1(10'h202);
      step();                         // edge 19
      chk("redir_ins", ins, 0);
      chk("redir_vld", ins_valid, 0);
      chk("redir_qc", queue_count, 0);
      redirect = 1'b0;
      step(); chk("bub1_vld", ins_valid, 0);   // 20
      step(); chk("bub2_vld", ins_valid, 0);   // 21
      step();                                  // 22
      chk("tgt_vld", ins_valid, 1);
      chk("tgt_pc", ins_pc, 10'h200);
      step(); step();                          // 23, 24

      // redirect and stall together
      redirect = 1'b1; stall = 1'b1; redirect_pc = 10'h100;
      step();                                  // 25
      chk("rs_ins", ins, 0);
      chk("rs_vld", ins_valid, 0);
      chk("rs_qc", queue_count, 0);
      redirect = 1'b0; stall = 1'b0;
      #1;
      chk("rs_addr", imem_addr, 10'h100);
      chk("rs_req", imem_req, 1);
      for (int p = 0; p < 4; p++) push1(10'h100 + 10'(p));
      repeat (6) step();                       // 26..31

      // stall until 3 are queued, then async reset mid-cycle
      stall = 1'b1;
      step(); step();                          // 32, 33
      chk("pre_rst_qc", queue_count, 3);
      chk("pre_rst_pc", ins_pc, 10'h103);
      #2 rst = 1'b1;
      #1;
      chk("arst_ins", ins, 0);
      chk("arst_vld", ins_valid, 0);
      chk("arst_qc", queue_count, 0);
      chk("arst_req", imem_req, 0);
      step(); step();                          // 34, 35
      push1(10'h000); push1(10'h001); push1(10'h002);
      rst = 1'b0; stall = 1'b0;
      step(); chk("rr1_vld", ins_valid, 0);    // 36
      step(); chk("rr2_vld", ins_valid, 0);    // 37
      step();                                  // 38
      chk("rr_vld", ins_valid, 1);
      chk("rr_pc", ins_pc, 10'h000);
      step(); step();                          // 39, 40
      @(negedge clk);
      #1 rst = 1'b1; rst2 = 1'b1;
      repeat (2) @(negedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
